// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned NIBBLE_W = 4;

  // Nibble index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/adder4_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// With NSA_OVF_EN defined it also exports c3, the carry into bit 3.
module adder4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
`ifdef NSA_OVF_EN
  ,
  output logic                c3
`endif
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign cout = carry[NIBBLE_W];

`ifdef NSA_OVF_EN
  assign c3 = carry[NIBBLE_W - 1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit slice, one nibble per clock, with start/done handshake.
// Optional signed-overflow output is enabled by defining NSA_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout
`ifdef NSA_OVF_EN
  ,
  output logic                        ovf
`endif
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic               s_cout;
`ifdef NSA_OVF_EN
  logic               ovf_q, ovf_d;
  logic               s_c3;
`endif

  adder4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (s_nib),
    .cout (s_cout)
`ifdef NSA_OVF_EN
    ,
    .c3   (s_c3)
`endif
  );

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (idx_q == IdxW'(k)) begin
        a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef NSA_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned k = 0; k < NIBBLES; k++) begin
          if (idx_q == IdxW'(k)) sum_d[k*NIBBLE_W +: NIBBLE_W] = s_nib;
        end
        carry_d = s_cout;
        if (idx_q == LastIdx) begin
          // idx parks on the last nibble; the next accepted start rewinds it.
          cout_d  = s_cout;
`ifdef NSA_OVF_EN
          ovf_d   = s_c3 ^ s_cout;
`endif
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NSA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef NSA_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;
`ifdef NSA_OVF_EN
  logic        ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int n_overlap = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NSA_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) n_overlap++;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE, scramble operands after acceptance, check timing and result.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec);
    int cyc = 0;
    int bcnt = 0;
    bit seen = 0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = '0; b = '0; cin = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    check({tag, " done_cycle"}, cyc, 5);
    check({tag, " busy_cycles"}, bcnt, 4);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " sum_held"}, sum, es);
  endtask

  vec_t vecs[7];

  initial begin
    int done_at[$];
    int ndone;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h6A4F, 16'hB93F, 1'b1, 16'h238F, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
`ifdef NSA_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                             vecs[i].sum, vecs[i].cout);

    // start held over edges E0..E19: accepts at E0, E6, E12 (and E18, drained later).
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(i);
        check($sformatf("held sum@%0d", i), sum, 16'h0002);
      end
    end
    start = 1'b0;
    ndone = done_at.size();
    check("held done_count", ndone, 3);
    if (ndone == 3) begin
      check("held spacing1", done_at[1] - done_at[0], 6);
      check("held spacing2", done_at[2] - done_at[1], 6);
    end
    begin
      int guard = 0;
      while (!done && guard < 20) begin @(negedge clk); guard++; end
      check("held drain", done, 1);
      @(negedge clk);
    end

    // Reset at E2 of an operation aborts it.
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    @(negedge clk) rst_n = 1'b1;
    begin
      int nd = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done || busy) nd++;
      end
      check("abort no_activity", nd, 0);
    end
    run_op("after_reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

`ifdef NSA_OVF_EN
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    check("ovf_pos ovf", ovf, 1);
    run_op("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    check("ovf_wrap ovf", ovf, 0);
`endif

    check("busy_done_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
